// File: rtl/ophu_pkg.sv
// Shared definitions for the ophu token transmitter: FSM state encodings and timer width.
package ophu_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/ophu_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases; expire_c flags the last counted cycle.
module ophu_timer
  import ophu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  // Expiry is the edge on which the count would reach zero.
  assign expire_c = (count == TIMER_W'(1));

endmodule

// File: rtl/ophu.sv
// Output-port handshake unit: turns queued send requests into p/n toggle tokens under credit control.
// Optional stall watchdog built only when OPHU_WATCHDOG_EN is defined.
module ophu
  import ophu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CREDITS     = 4,
  parameter int unsigned PEND_DEPTH  = 8,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             send_req,
  input  logic                             credit_in,
  output logic                             diff_pair_p,
  output logic                             diff_pair_n,
  output logic                             busy,
  output logic [$clog2(PEND_DEPTH+1)-1:0]  pending_cnt,
  output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
  output logic                             overflow,
  output logic                             credit_err,
  output logic                             stall_err
);

  localparam int unsigned PEND_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  state_t             state_q, state_d;
  logic               load_c;
  logic [TIMER_W-1:0] load_val_c;
  logic               expire_c;
  logic               tog_p_c, tog_n_c;
  logic               deq_c;

  ophu_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (load_val_c),
    .expire_c (expire_c)
  );

  // Next-state and token control.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    load_val_c = '0;
    tog_p_c    = 1'b0;
    tog_n_c    = 1'b0;
    deq_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_cnt != '0 && credit_cnt != '0) begin
          tog_p_c    = 1'b1;
          deq_c      = 1'b1;
          load_c     = 1'b1;
          load_val_c = TIMER_W'(HOLD_CYCLES);
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (expire_c) begin
          tog_n_c    = 1'b1;
          load_c     = 1'b1;
          load_val_c = TIMER_W'(GAP_CYCLES);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (expire_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, line pair and busy; reset drops the pair balanced even mid-token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      diff_pair_p <= 1'b0;
      diff_pair_n <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      diff_pair_p <= diff_pair_p ^ tog_p_c;
      diff_pair_n <= diff_pair_n ^ tog_n_c;
      busy        <= (state_d != ST_IDLE);
    end
  end

  // Request queue counter; a request arriving when full with no dequeue is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      case ({send_req, deq_c})
        2'b10: begin
          if (pending_cnt == PEND_W'(PEND_DEPTH)) begin
            overflow <= 1'b1;
          end else begin
            pending_cnt <= pending_cnt + PEND_W'(1);
          end
        end
        2'b01:   pending_cnt <= pending_cnt - PEND_W'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  // Credit counter; a return beyond the maximum saturates and flags an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= CRED_W'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      case ({credit_in, deq_c})
        2'b10: begin
          if (credit_cnt == CRED_W'(CREDITS)) begin
            credit_err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + CRED_W'(1);
          end
        end
        2'b01:   credit_cnt <= credit_cnt - CRED_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

`ifdef OPHU_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            stall_q;

  // Counts consecutive cycles with work queued but no credit to send it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      stall_q <= 1'b0;
    end else if (pending_cnt != '0 && credit_cnt == '0) begin
      if (wd_cnt != WD_W'(WDOG_CYCLES)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) begin
        stall_q <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end

  assign stall_err = stall_q;
`else
  logic unused_wdog;
  assign unused_wdog = |32'(WDOG_CYCLES);
  assign stall_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ophu.sv
// Scoreboard bench for ophu: expected p/n toggle events are queued by the stimulus and popped by a monitor.
module tb_ophu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_req = 1'b0;
  logic       credit_in = 1'b0;
  logic       diff_pair_p, diff_pair_n, busy;
  logic [3:0] pending_cnt;
  logic [2:0] credit_cnt;
  logic       overflow, credit_err, stall_err;

  ophu dut (
    .clk         (clk),
    .reset       (reset),
    .send_req    (send_req),
    .credit_in   (credit_in),
    .diff_pair_p (diff_pair_p),
    .diff_pair_n (diff_pair_n),
    .busy        (busy),
    .pending_cnt (pending_cnt),
    .credit_cnt  (credit_cnt),
    .overflow    (overflow),
    .credit_err  (credit_err),
    .stall_err   (stall_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_n;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_miss = 0;
  logic p_prev = 1'b0, n_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expect a token whose p toggles after edge e and whose n closes it HOLD_CYCLES=2 edges later.
  task automatic push_tok(input int e);
    exp_q.push_back('{is_n: 1'b0, cyc: e});
    exp_q.push_back('{is_n: 1'b1, cyc: e + 2});
  endtask

  task automatic step(input bit sr, input bit ci);
    send_req  = sr;
    credit_in = ci;
    @(negedge clk);
    send_req  = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    chk("queue_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every line toggle must match the next queued event in kind and cycle.
  always @(negedge clk) begin
    if (reset) begin
      p_prev <= diff_pair_p;
      n_prev <= diff_pair_n;
    end else begin
      if (diff_pair_p != p_prev && diff_pair_n != n_prev) begin
        chk("p_n_same_cycle", 1, 0);
      end else if (diff_pair_p != p_prev || diff_pair_n != n_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_toggle_n", int'(diff_pair_n != n_prev), -1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("toggle_kind_is_n", int'(diff_pair_n != n_prev), int'(e.is_n));
          chk("toggle_cycle", cyc, e.cyc);
        end
      end
      p_prev <= diff_pair_p;
      n_prev <= diff_pair_n;
    end
  end

  int b, e, busy_cycles;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_p", int'(diff_pair_p), 0);
    chk("rst_n", int'(diff_pair_n), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending_cnt), 0);
    chk("rst_credit", int'(credit_cnt), 4);
    chk("rst_flags", int'({overflow, credit_err, stall_err}), 0);

    // 1: single token, busy for three cycles
    b = cyc + 1;
    push_tok(b + 1);
    step(1'b1, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (busy) busy_cycles++;
    end
    chk("t1_busy_cycles", busy_cycles, 3);
    chk("t1_credit", int'(credit_cnt), 3);
    chk("t1_pending", int'(pending_cnt), 0);
    step(1'b0, 1'b1);
    chk("t1_credit_back", int'(credit_cnt), 4);

    // 2: six back-to-back requests, four credits
    b = cyc + 1;
    push_tok(b + 1);
    push_tok(b + 5);
    push_tok(b + 9);
    push_tok(b + 13);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    while (cyc < b + 17) step(1'b0, 1'b0);
    chk("t2_pending", int'(pending_cnt), 2);
    chk("t2_credit", int'(credit_cnt), 0);
    chk("t2_busy", int'(busy), 0);

    // 3: two credits back; the second coincides with a spend
    b = cyc + 1;
    push_tok(b + 1);
    push_tok(b + 5);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("t3_credit_spend_same_cycle", int'(credit_cnt), 1);
    while (cyc < b + 8) step(1'b0, 1'b0);
    chk("t3_pending", int'(pending_cnt), 0);
    chk("t3_credit", int'(credit_cnt), 0);
    chk("t3_credit_err", int'(credit_err), 0);

    // 4: queue saturation with no credits
    b = cyc + 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("t4_pending_sat", int'(pending_cnt), 8);
    chk("t4_overflow", int'(overflow), 1);
    e = cyc + 1;
    push_tok(e + 1);
    step(1'b1, 1'b1);
    chk("t4_pending_full_req_credit", int'(pending_cnt), 8);
    chk("t4_credit_one", int'(credit_cnt), 1);
    while (cyc < e + 6) step(1'b0, 1'b0);
    chk("t4_pending_after_token", int'(pending_cnt), 7);
    chk("t4_credit_after_token", int'(credit_cnt), 0);
    do_reset();
    chk("t4_overflow_cleared", int'(overflow), 0);
    chk("t4_pending_cleared", int'(pending_cnt), 0);

    // 5: credit return at the maximum
    step(1'b0, 1'b1);
    chk("t5_credit_sat", int'(credit_cnt), 4);
    chk("t5_credit_err", int'(credit_err), 1);

    // 6: reset in the middle of HOLD
    b = cyc + 1;
    exp_q.push_back('{is_n: 1'b0, cyc: b + 1});
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t6_hold_p", int'(diff_pair_p), 1);
    chk("t6_hold_n", int'(diff_pair_n), 0);
    #1;
    chk("t6_queue_empty", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_p", int'(diff_pair_p), 0);
    chk("t6_rst_n", int'(diff_pair_n), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_credit", int'(credit_cnt), 4);
    chk("t6_rst_pending", int'(pending_cnt), 0);
    chk("t6_rst_credit_err", int'(credit_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    chk("t6_no_spurious_p", int'(diff_pair_p), 0);

`ifdef OPHU_WATCHDOG_EN
    // Watchdog: one request stuck with zero credits
    b = cyc + 1;
    push_tok(b + 1);
    push_tok(b + 5);
    push_tok(b + 9);
    push_tok(b + 13);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    while (cyc < b + 70) step(1'b0, 1'b0);
    chk("wd_pending", int'(pending_cnt), 1);
    chk("wd_not_yet", int'(stall_err), 0);
    while (cyc < b + 80) step(1'b0, 1'b0);
    chk("wd_stall_err", int'(stall_err), 1);
`else
    chk("stall_err_tied", int'(stall_err), 0);
`endif

    repeat (2) step(1'b0, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
